// File: rtl/ws2811_pkg.sv
// ws2811_pkg
// Shared types and default timing for the WS2811 frame sequencer.
// Timing defaults assume a 50 MHz clock.
package ws2811_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } seqState_t;

  localparam int PIXEL_BITS         = 24;
  localparam int DEF_PIXEL_COUNT    = 64;
  localparam int DEF_T0H_CYCLES     = 20;    // 0.4 us
  localparam int DEF_T1H_CYCLES     = 40;    // 0.8 us
  localparam int DEF_BIT_CYCLES     = 63;    // 1.25 us
  localparam int DEF_RESET_CYCLES   = 2500;  // 50 us

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2811_frame_sequencer_if.sv
// ws2811_frame_sequencer_if
// Pixel handshake between the frame memory reader and the sequencer.
// Signals:
//   pixelIN        24-bit {G,R,B} pixel from the source
//   pixelValidIN   pixelIN holds a pixel
//   pixelReadyOUT  sequencer buffer can take it; transfer on valid && ready
// Modports: master = pixel source, slave = sequencer.
interface ws2811_frame_sequencer_if;
  import ws2811_pkg::*;

  logic [PIXEL_BITS-1:0] pixelIN;
  logic                  pixelValidIN;
  logic                  pixelReadyOUT;

  modport master (output pixelIN, output pixelValidIN, input pixelReadyOUT);
  modport slave  (input pixelIN, input pixelValidIN, output pixelReadyOUT);

endinterface

// File: rtl/CyclicShifter24.sv
// CyclicShifter24
// Combinational 24-bit rotate-left. out[23] equals dataIN[23-shiftIN].
// Ports:
//   dataIN   24-bit word
//   shiftIN  rotate amount 0..23 (larger values wrap modulo 24)
//   out      rotated word
module CyclicShifter24 (
  input  logic [23:0] dataIN,
  input  logic [4:0]  shiftIN,
  output logic [23:0] out
);

  logic [47:0] doubled;
  logic [4:0]  amt;

  assign doubled = {dataIN, dataIN};
  assign amt     = (shiftIN > 5'd23) ? (shiftIN - 5'd24) : shiftIN;
  // Window into the doubled word gives the rotation without a barrel of muxes per bit.
  assign out     = doubled[(6'd47 - {1'b0, amt}) -: 24];

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer
// Streams a frame of PIXEL_COUNT GRB pixels MSB-first onto one WS2811 data
// line, then holds the line low for the latch time. A one-entry prefetch
// buffer lets consecutive pixels follow each other without a gap.
// Ports:
//   clockIN, resetIN  system clock, asynchronous active-high reset
//   startIN           frame request, honoured only when idle
//   pixBus            pixel source handshake (slave side)
//   dataOUT           registered serial line
//   busyOUT           high from accepted start until the done pulse
//   doneOUT           1-cycle pulse at the end of the latch time
//   underrunOUT       1-cycle pulse when the next pixel was not buffered in time
//
// state | meaning
// IDLE  | line low, waiting for startIN
// FETCH | line low, waiting for the first pixel in the buffer
// SEND  | shifting bits out, chaining buffered pixels
// LATCH | line low for RESET_CYCLES clocks, then done
module ws2811_frame_sequencer
  import ws2811_pkg::*;
#(
  parameter int PIXEL_COUNT  = DEF_PIXEL_COUNT,
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic                      clockIN,
  input  logic                      resetIN,
  input  logic                      startIN,
  ws2811_frame_sequencer_if.slave   pixBus,
  output logic                      dataOUT,
  output logic                      busyOUT,
  output logic                      doneOUT,
  output logic                      underrunOUT
);

  localparam int CW = $clog2(maxInt(BIT_CYCLES, RESET_CYCLES));
  localparam int PW = $clog2(PIXEL_COUNT + 1);

  if (!((T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES) &&
        (PIXEL_COUNT >= 1) && (RESET_CYCLES >= 1))) begin : gParamCheck
    $error("ws2811_frame_sequencer: need T0H < T1H < BIT, PIXEL_COUNT >= 1, RESET >= 1");
  end

  seqState_t             state, stateNext;
  logic [CW-1:0]         cycCnt;
  logic [4:0]            bitIdx;
  logic [PW-1:0]         fetchedCnt, sentCnt;
  logic [PIXEL_BITS-1:0] shiftReg, bufReg;
  logic                  bufFull;

  logic [PIXEL_BITS-1:0] shOut;
  logic                  unusedShOut;
  logic                  curBit, bitEnd, pixEnd, latchEnd, startOk, fill;
  logic                  frameStart, load, dataNext, doneNext, underrunNext;

  CyclicShifter24 u_shifter (
    .dataIN  (shiftReg),
    .shiftIN (bitIdx),
    .out     (shOut)
  );

  assign curBit      = shOut[23];
  assign unusedShOut = ^shOut[22:0];

  assign bitEnd   = (cycCnt == CW'(BIT_CYCLES - 1));
  assign pixEnd   = bitEnd && (bitIdx == 5'd23);
  assign latchEnd = (cycCnt == CW'(RESET_CYCLES - 1));
  // doneOUT is visible in the first IDLE cycle; a start there must not re-trigger.
  assign startOk  = startIN && !doneOUT;

  assign pixBus.pixelReadyOUT = busyOUT && !bufFull && (state != LATCH) &&
                                (fetchedCnt < PW'(PIXEL_COUNT));
  assign fill = pixBus.pixelValidIN && pixBus.pixelReadyOUT;

  // state register
  always_ff @(posedge clockIN or posedge resetIN) begin
    if (resetIN) state <= IDLE;
    else         state <= stateNext;
  end

  // next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startOk) stateNext = FETCH;
      FETCH:   if (bufFull) stateNext = SEND;
      SEND:    if (pixEnd && ((sentCnt == PW'(PIXEL_COUNT)) || !bufFull)) stateNext = LATCH;
      LATCH:   if (latchEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // outputs / datapath controls
  always_comb begin
    frameStart   = 1'b0;
    load         = 1'b0;
    dataNext     = 1'b0;
    doneNext     = 1'b0;
    underrunNext = 1'b0;
    case (state)
      IDLE:  frameStart = startOk;
      FETCH: load = bufFull;
      SEND: begin
        dataNext = (cycCnt < (curBit ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));
        if (pixEnd && (sentCnt != PW'(PIXEL_COUNT))) begin
          if (bufFull) load = 1'b1;
          else         underrunNext = 1'b1;
        end
      end
      LATCH: doneNext = latchEnd;
      default: ;
    endcase
  end

  always_ff @(posedge clockIN or posedge resetIN) begin
    if (resetIN) begin
      dataOUT     <= 1'b0;
      busyOUT     <= 1'b0;
      doneOUT     <= 1'b0;
      underrunOUT <= 1'b0;
      cycCnt      <= '0;
      bitIdx      <= '0;
      fetchedCnt  <= '0;
      sentCnt     <= '0;
      shiftReg    <= '0;
      bufReg      <= '0;
      bufFull     <= 1'b0;
    end else begin
      dataOUT     <= dataNext;
      doneOUT     <= doneNext;
      underrunOUT <= underrunNext;

      if (frameStart)    busyOUT <= 1'b1;
      else if (doneNext) busyOUT <= 1'b0;

      if (stateNext != state)  cycCnt <= '0;
      else if (state == SEND)  cycCnt <= bitEnd ? '0 : cycCnt + CW'(1);
      else if (state == LATCH) cycCnt <= cycCnt + CW'(1);

      if (load)
        bitIdx <= '0;
      else if ((state == SEND) && bitEnd && (bitIdx != 5'd23))
        bitIdx <= bitIdx + 5'd1;

      if (load) shiftReg <= bufReg;

      if (frameStart) begin
        fetchedCnt <= '0;
        sentCnt    <= '0;
        bufFull    <= 1'b0;
      end else begin
        if (fill) fetchedCnt <= fetchedCnt + PW'(1);
        if (load) sentCnt    <= sentCnt + PW'(1);
        // a fill in the same cycle as a drain leaves the new pixel buffered
        bufFull <= (bufFull && !load) || fill;
      end

      if (fill) bufReg <= pixBus.pixelIN;
    end
  end

endmodule
